// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: baud divider, 5-9 data bits, optional parity, 1-2 stop bits.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry input FIFO in front of the serialiser.
module uart_tx_param #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_valid,
    input  logic [DATA_BITS-1:0] data,
    output logic                 data_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int unsigned BAUD_W     = $clog2(CLK_DIV);
    localparam int unsigned BIT_W      = $clog2(DATA_BITS);
    localparam bit          HAS_PARITY = (PARITY == 1) || (PARITY == 2);
    localparam bit          ODD_PARITY = (PARITY == 1);

    if (CLK_DIV < 2) begin : g_chk_clk_div
        $error("uart_tx_param: CLK_DIV must be 2 or more");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY > 3) begin : g_chk_parity
        $error("uart_tx_param: PARITY must be 0..3");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fifo_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two, 2 or more");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e               state_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_q;
    logic                 tx_q;
    logic                 tx_done_q;

    logic                 tick_c;
    logic                 last_stop_c;
    logic                 pre_last_stop_c;
    logic                 load_c;
    logic [DATA_BITS-1:0] load_data_c;

    assign tick_c          = (baud_q == BAUD_W'(CLK_DIV - 1));
    assign last_stop_c     = (state_q == S_STOP) && tick_c && (bit_q == BIT_W'(STOP_BITS - 1));
    // tx_done is registered, so it is armed one cycle ahead of the final stop tick
    assign pre_last_stop_c = (state_q == S_STOP) && (baud_q == BAUD_W'(CLK_DIV - 2))
                             && (bit_q == BIT_W'(STOP_BITS - 1));

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wptr_q;
    logic [PTR_W-1:0]     rptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 push_c;
    logic                 full_c;
    logic                 empty_c;

    assign full_c      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_c     = (count_q == '0);
    assign push_c      = data_valid && !full_c;
    assign load_c      = ((state_q == S_IDLE) || last_stop_c) && !empty_c;
    assign load_data_c = mem_q[rptr_q];
    assign data_ready  = !full_c;
    assign busy        = (state_q != S_IDLE) || !empty_c;

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wptr_q] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_c) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (load_c) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_c) - CNT_W'(load_c);
        end
    end
`else
    assign data_ready  = (state_q == S_IDLE) || last_stop_c;
    assign load_c      = data_valid && data_ready;
    assign load_data_c = data;
    assign busy        = (state_q != S_IDLE);
`endif

    // Serialiser: a load always lands in START, also straight from the final stop tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= pre_last_stop_c;
            baud_q    <= (state_q == S_IDLE || tick_c) ? '0 : baud_q + BAUD_W'(1);
            if (load_c) begin
                state_q <= S_START;
                baud_q  <= '0;
                bit_q   <= '0;
                shreg_q <= load_data_c;
                par_q   <= (^load_data_c) ^ ODD_PARITY;
                tx_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        tx_q <= 1'b1;
                    end
                    S_START: begin
                        if (tick_c) begin
                            state_q <= S_DATA;
                            bit_q   <= '0;
                            tx_q    <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                        end
                    end
                    S_DATA: begin
                        if (tick_c) begin
                            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                                bit_q <= '0;
                                if (HAS_PARITY) begin
                                    state_q <= S_PARITY;
                                    tx_q    <= par_q;
                                end else begin
                                    state_q <= S_STOP;
                                    tx_q    <= 1'b1;
                                end
                            end else begin
                                bit_q   <= bit_q + BIT_W'(1);
                                tx_q    <= shreg_q[0];
                                shreg_q <= shreg_q >> 1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (tick_c) begin
                            state_q <= S_STOP;
                            bit_q   <= '0;
                            tx_q    <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (tick_c) begin
                            if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                                state_q <= S_IDLE;
                                bit_q   <= '0;
                            end else begin
                                bit_q <= bit_q + BIT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx      = tx_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameterisations share clock and reset.
// Expected tx levels are hand-built per frame, LSB = start bit.
module tb_uart_tx_param;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] valid;
    logic [7:0] din [4];
    wire  [3:0] rdy;
    wire  [3:0] txs;
    wire  [3:0] bsy;
    wire  [3:0] dne;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    uart_tx_param u0 (
        .clk(clk), .rst(rst), .data_valid(valid[0]), .data(din[0]),
        .data_ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]), .tx_done(dne[0])
    );
    uart_tx_param #(.DATA_BITS(7), .PARITY(2)) u1 (
        .clk(clk), .rst(rst), .data_valid(valid[1]), .data(din[1][6:0]),
        .data_ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]), .tx_done(dne[1])
    );
    uart_tx_param #(.DATA_BITS(7), .PARITY(1)) u2 (
        .clk(clk), .rst(rst), .data_valid(valid[2]), .data(din[2][6:0]),
        .data_ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]), .tx_done(dne[2])
    );
    uart_tx_param #(.CLK_DIV(3), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .data_valid(valid[3]), .data(din[3]),
        .data_ready(rdy[3]), .tx(txs[3]), .busy(bsy[3]), .tx_done(dne[3])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a byte and wait (bounded) until it is taken; returns at accept edge + 1.
    task automatic send(input int s, input logic [7:0] d, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        valid[s] = 1'b1;
        din[s]   = d;
        while (!rdy[s] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_timeout", 32'(n >= 200), 32'd0);
        @(posedge clk);
        #1;
        if (!hold) valid[s] = 1'b0;
`ifdef UART_TX_FIFO_EN
        check_eq("fifo_extra_latency_tx", txs[s], 1'b1);
        @(posedge clk);
        #1;
`endif
    endtask

    // Check tx level, tx_done and data_ready on every cycle of one frame.
    task automatic check_frame(input int s, input int cdiv, input int nbits,
                               input logic [15:0] bits, input int pulse_k);
        int len;
        len = cdiv * nbits;
        for (int k = 0; k < len; k++) begin
            check_eq($sformatf("u%0d_tx[%0d]", s, k), txs[s], bits[k / cdiv]);
            check_eq($sformatf("u%0d_done[%0d]", s, k), dne[s], 32'(k == len - 1));
`ifndef UART_TX_FIFO_EN
            check_eq($sformatf("u%0d_ready[%0d]", s, k), rdy[s], 32'(k == len - 1));
`endif
            if (pulse_k >= 0 && k == pulse_k) begin
                valid[s] = 1'b1;
                din[s]   = 8'h3C;
            end else if (pulse_k >= 0 && k == pulse_k + 1) begin
                valid[s] = 1'b0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle(input int s);
        check_eq($sformatf("u%0d_idle_busy", s), bsy[s], 1'b0);
        check_eq($sformatf("u%0d_idle_tx", s), txs[s], 1'b1);
        check_eq($sformatf("u%0d_idle_done", s), dne[s], 1'b0);
    endtask

`ifdef UART_TX_FIFO_EN
    logic rec = 1'b0;
    logic tx_tr [$];
    logic bsy_tr [$];
    always @(negedge clk) begin
        if (rec) begin
            tx_tr.push_back(txs[0]);
            bsy_tr.push_back(bsy[0]);
        end
    end
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        valid = '0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            check_eq($sformatf("u%0d_rst_tx", s), txs[s], 1'b1);
            check_eq($sformatf("u%0d_rst_busy", s), bsy[s], 1'b0);
            check_eq($sformatf("u%0d_rst_done", s), dne[s], 1'b0);
            check_eq($sformatf("u%0d_rst_ready", s), rdy[s], 1'b1);
        end
        @(negedge clk);
        rst = 1'b0;

        // 0xA5, 8N1: levels 0,1,0,1,0,0,1,0,1,1
        send(0, 8'hA5, 1'b0);
        check_frame(0, 4, 10, 16'h034A, -1);
        check_idle(0);

        // 0x07, 7 bits, even parity -> parity 1
        send(1, 8'h07, 1'b0);
        check_frame(1, 4, 10, 16'h030E, -1);
        check_idle(1);

        // 0x07, 7 bits, odd parity -> parity 0
        send(2, 8'h07, 1'b0);
        check_frame(2, 4, 10, 16'h020E, -1);
        check_idle(2);

`ifndef UART_TX_FIFO_EN
        // Held valid: 0x55 then 0xAA, two stop bits, no gap between frames
        send(3, 8'h55, 1'b1);
        din[3] = 8'hAA;
        check_frame(3, 3, 11, 16'h06AA, -1);
        valid[3] = 1'b0;
        check_frame(3, 3, 11, 16'h0754, -1);
        check_idle(3);

        // Mid-frame valid pulse is ignored
        send(0, 8'hA5, 1'b0);
        check_frame(0, 4, 10, 16'h034A, 10);
        check_idle(0);
        repeat (5) @(posedge clk);
        #1;
        check_idle(0);

        // Async reset during data bit 3 of 0xFF
        send(0, 8'hFF, 1'b0);
        repeat (17) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", bsy[0], 1'b1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_tx", txs[0], 1'b1);
        check_eq("async_rst_busy", bsy[0], 1'b0);
        check_eq("async_rst_ready", rdy[0], 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        begin
            int done_seen;
            int tx_low_seen;
            done_seen   = 0;
            tx_low_seen = 0;
            repeat (50) begin
                @(negedge clk);
                done_seen   += int'(dne[0]);
                tx_low_seen += int'(!txs[0]);
            end
            check_eq("post_rst_done_count", 32'(done_seen), 32'd0);
            check_eq("post_rst_tx_low_count", 32'(tx_low_seen), 32'd0);
            check_eq("post_rst_ready", rdy[0], 1'b1);
            check_eq("post_rst_busy", bsy[0], 1'b0);
        end
`else
        // Burst of five bytes through the FIFO, serialised in order without gaps
        begin
            logic [7:0] q [5];
            logic [7:0] got;
            int pushed;
            int n;
            int start;
            int busy_low;
            logic acc;
            q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
            pushed = 0;
            n = 0;
            @(negedge clk);
            rec = 1'b1;
            while (pushed < 5 && n < 100) begin
                valid[0] = 1'b1;
                din[0]   = q[pushed];
                acc      = rdy[0];
                @(negedge clk);
                if (acc) pushed++;
                n++;
            end
            valid[0] = 1'b0;
            check_eq("fifo_pushed", 32'(pushed), 32'd5);
            repeat (230) @(negedge clk);
            rec = 1'b0;
            start = -1;
            for (int i = 0; i < tx_tr.size(); i++) begin
                if (start < 0 && tx_tr[i] == 1'b0) start = i;
            end
            check_eq("fifo_first_start", 32'(start), 32'd2);
            if (start >= 0 && tx_tr.size() > start + 200) begin
                busy_low = 0;
                for (int i = 1; i < start + 200; i++) busy_low += int'(!bsy_tr[i]);
                check_eq("fifo_busy_low", 32'(busy_low), 32'd0);
                for (int f = 0; f < 5; f++) begin
                    for (int b = 0; b < 8; b++) got[b] = tx_tr[start + f * 40 + 4 * (1 + b) + 2];
                    check_eq($sformatf("fifo_start[%0d]", f), tx_tr[start + f * 40 + 2], 1'b0);
                    check_eq($sformatf("fifo_byte[%0d]", f), got, q[f]);
                    check_eq($sformatf("fifo_stop[%0d]", f), tx_tr[start + f * 40 + 38], 1'b1);
                end
            end else begin
                check_eq("fifo_trace_len", 32'(tx_tr.size()), 32'(start + 201));
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
